// File: rtl/msp430_trace_dii_pkg.sv
// Shared types and constants for the MSP430 execution-trace DII transmitter.
package msp430_trace_dii_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        wben;
        logic [4:0]  wbreg;
        logic [31:0] wbdata;
        logic [31:0] ts;
    } trace_rec_t;

    typedef enum logic [2:0] {
        IDLE,
        HDR_DEST,
        HDR_SRC,
        HDR_TYPE,
        PAYLOAD,
        OVF_CNT
    } fsm_state_t;

    localparam logic [1:0] TYPE_CLASS   = 2'b10;
    localparam logic [3:0] SUB_EXEC     = 4'd0;
    localparam logic [3:0] SUB_EXEC_WB  = 4'd1;
    localparam logic [3:0] SUB_OVERFLOW = 4'd2;

    localparam int unsigned LEN_EXEC     = 9;
    localparam int unsigned LEN_EXEC_WB  = 12;
    localparam int unsigned LEN_OVERFLOW = 4;

    function automatic logic [15:0] type_flit(input logic [3:0] sub);
        return {TYPE_CLASS, sub, 10'b0};
    endfunction

endpackage

// File: rtl/msp430_trace_dii_tx_fifo.sv
// Single-clock FIFO of trace records with a registered head entry.
module trace_rec_fifo
    import msp430_trace_dii_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  trace_rec_t wdata,
    input  logic       pop,
    output trace_rec_t head,
    output logic       full,
    output logic       empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

    trace_rec_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  rd_nxt;
    logic [AW:0]    count;

    assign rd_nxt = rd_ptr + 1'b1;
    assign full   = (count == CNT_FULL);
    assign empty  = (count == '0);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end

    // head mirrors mem[rd_ptr]; on a pop it is refilled from the next entry,
    // or from the incoming write when that write is the only remaining record
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_nxt;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (pop) begin
                if (count > 1)
                    head <= mem[rd_nxt];
                else if (push)
                    head <= wdata;
            end else if (push && empty) begin
                head <= wdata;
            end
        end
    end

endmodule

// File: rtl/msp430_trace_dii_tx.sv
// Buffers retired-instruction records and serialises them as DII event packets.
module msp430_trace_dii_tx
    import msp430_trace_dii_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned MAX_PKT_LEN = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] id,
    input  logic [15:0] dest,
    input  logic        enable,
    input  logic        trace_valid,
    input  logic [31:0] trace_pc,
    input  logic [31:0] trace_insn,
    input  logic        trace_wben,
    input  logic [4:0]  trace_wbreg,
    input  logic [31:0] trace_wbdata,
    output logic [15:0] debug_out_data,
    output logic        debug_out_valid,
    output logic        debug_out_last,
    input  logic        debug_out_ready,
    output logic [15:0] overflow_cnt,
    output logic        busy
);
    localparam int unsigned IDX_W = $clog2(MAX_PKT_LEN);

    fsm_state_t        state, state_n;
    trace_rec_t        wrec, fifo_head, pkt;
    logic              fifo_full, fifo_empty;
    logic              push, drop, start_ovf, start_rec, want_next, xfer;
    logic              pkt_ovf;
    logic [15:0]       ovf_val, id_q;
    logic [31:0]       ts;
    logic [IDX_W-1:0]  idx, idx_n, idx_inc, last_idx;
    logic [15:0]       data_n;
    logic              valid_n, last_n;
    logic [15:0]       pay [2**IDX_W];

    assign push = trace_valid & enable & ~fifo_full;
    assign drop = trace_valid & enable & fifo_full;
    assign busy = ~fifo_empty | (state != IDLE) | (overflow_cnt != '0);
    assign xfer = debug_out_valid & debug_out_ready;

    always_comb begin
        wrec        = '0;
        wrec.pc     = trace_pc;
        wrec.insn   = trace_insn;
        wrec.wben   = trace_wben;
        wrec.wbreg  = trace_wbreg;
        wrec.wbdata = trace_wbdata;
        wrec.ts     = ts;
    end

    trace_rec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wrec),
        .pop   (start_rec),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        for (int unsigned i = 0; i < 2**IDX_W; i++)
            pay[i] = '0;
        pay[0] = pkt.ts[15:0];
        pay[1] = pkt.ts[31:16];
        pay[2] = pkt.pc[15:0];
        pay[3] = pkt.pc[31:16];
        pay[4] = pkt.insn[15:0];
        pay[5] = pkt.insn[31:16];
        pay[6] = {11'b0, pkt.wbreg};
        pay[7] = pkt.wbdata[15:0];
        pay[8] = pkt.wbdata[31:16];
    end

    // payload index of the final flit: packet length minus three header flits, zero-based
    assign last_idx = pkt.wben ? IDX_W'(LEN_EXEC_WB - 4) : IDX_W'(LEN_EXEC - 4);
    assign idx_inc  = idx + 1'b1;

    always_comb begin
        state_n   = state;
        data_n    = debug_out_data;
        valid_n   = debug_out_valid;
        last_n    = debug_out_last;
        idx_n     = idx;
        want_next = 1'b0;
        start_ovf = 1'b0;
        start_rec = 1'b0;
        case (state)
            IDLE: want_next = 1'b1;
            HDR_DEST: if (xfer) begin
                state_n = HDR_SRC;
                data_n  = id_q;
            end
            HDR_SRC: if (xfer) begin
                state_n = HDR_TYPE;
                data_n  = type_flit(pkt_ovf ? SUB_OVERFLOW : (pkt.wben ? SUB_EXEC_WB : SUB_EXEC));
            end
            HDR_TYPE: if (xfer) begin
                if (pkt_ovf) begin
                    state_n = OVF_CNT;
                    data_n  = ovf_val;
                    last_n  = 1'b1;
                end else begin
                    state_n = PAYLOAD;
                    idx_n   = '0;
                    data_n  = pay[0];
                end
            end
            PAYLOAD: if (xfer) begin
                if (idx == last_idx) begin
                    want_next = 1'b1;
                end else begin
                    idx_n  = idx_inc;
                    data_n = pay[idx_inc];
                    last_n = (idx_inc == last_idx);
                end
            end
            OVF_CNT: if (xfer) want_next = 1'b1;
            default: state_n = IDLE;
        endcase

        // the next packet starts in the same cycle the previous one ends
        if (want_next) begin
            state_n = IDLE;
            valid_n = 1'b0;
            last_n  = 1'b0;
            data_n  = '0;
            if (overflow_cnt != '0 || !fifo_empty) begin
                start_ovf = (overflow_cnt != '0);
                start_rec = (overflow_cnt == '0);
                state_n   = HDR_DEST;
                valid_n   = 1'b1;
                data_n    = dest;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            debug_out_data  <= '0;
            debug_out_valid <= 1'b0;
            debug_out_last  <= 1'b0;
            idx             <= '0;
            pkt             <= '0;
            pkt_ovf         <= 1'b0;
            ovf_val         <= '0;
            id_q            <= '0;
            overflow_cnt    <= '0;
            ts              <= '0;
        end else begin
            state           <= state_n;
            debug_out_data  <= data_n;
            debug_out_valid <= valid_n;
            debug_out_last  <= last_n;
            idx             <= idx_n;
            ts              <= ts + 32'd1;
            if (start_ovf) begin
                pkt_ovf <= 1'b1;
                ovf_val <= overflow_cnt;
                id_q    <= id;
            end
            if (start_rec) begin
                pkt_ovf <= 1'b0;
                pkt     <= fifo_head;
                id_q    <= id;
            end
            if (start_ovf)
                overflow_cnt <= {15'b0, drop};
            else if (drop && overflow_cnt != '1)
                overflow_cnt <= overflow_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_msp430_trace_dii_tx.sv
// Directed bench for the trace DII transmitter with hand-built expected flit streams.
module tb_msp430_trace_dii_tx;
    localparam logic [15:0] ID  = 16'h1234;
    localparam logic [15:0] DST = 16'hABCD;

    logic        clk = 1'b0;
    logic        rst, enable, trace_valid, trace_wben, debug_out_ready;
    logic [15:0] id, dest;
    logic [31:0] trace_pc, trace_insn, trace_wbdata;
    logic [4:0]  trace_wbreg;
    logic [15:0] debug_out_data, overflow_cnt;
    logic        debug_out_valid, debug_out_last, busy;

    always #5 clk = ~clk;

    msp430_trace_dii_tx #(.FIFO_DEPTH(8), .MAX_PKT_LEN(12)) dut (
        .clk             (clk),
        .rst             (rst),
        .id              (id),
        .dest            (dest),
        .enable          (enable),
        .trace_valid     (trace_valid),
        .trace_pc        (trace_pc),
        .trace_insn      (trace_insn),
        .trace_wben      (trace_wben),
        .trace_wbreg     (trace_wbreg),
        .trace_wbdata    (trace_wbdata),
        .debug_out_data  (debug_out_data),
        .debug_out_valid (debug_out_valid),
        .debug_out_last  (debug_out_last),
        .debug_out_ready (debug_out_ready),
        .overflow_cnt    (overflow_cnt),
        .busy            (busy)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] tb_ts = '0;
    logic [15:0] got_q[$];
    logic        got_last[$];
    logic [15:0] exp_q[$];
    logic        exp_last[$];

    always @(posedge clk)
        if (rst) tb_ts <= '0;
        else     tb_ts <= tb_ts + 32'd1;

    always @(negedge clk)
        if (!rst && debug_out_valid && debug_out_ready) begin
            got_q.push_back(debug_out_data);
            got_last.push_back(debug_out_last);
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] insn, input logic wben,
                         input logic [4:0] wbreg, input logic [31:0] wbdata,
                         output logic [31:0] ts);
        trace_pc     = pc;
        trace_insn   = insn;
        trace_wben   = wben;
        trace_wbreg  = wbreg;
        trace_wbdata = wbdata;
        trace_valid  = 1'b1;
        ts           = tb_ts;
        step(1);
        trace_valid  = 1'b0;
    endtask

    task automatic put(input logic [15:0] d, input logic l);
        exp_q.push_back(d);
        exp_last.push_back(l);
    endtask

    task automatic add_exec(input logic [31:0] pc, input logic [31:0] insn, input logic wben,
                            input logic [4:0] wbreg, input logic [31:0] wbdata,
                            input logic [31:0] ts);
        put(DST, 1'b0);
        put(ID, 1'b0);
        put(wben ? 16'h8400 : 16'h8000, 1'b0);
        put(ts[15:0], 1'b0);
        put(ts[31:16], 1'b0);
        put(pc[15:0], 1'b0);
        put(pc[31:16], 1'b0);
        put(insn[15:0], 1'b0);
        put(insn[31:16], !wben);
        if (wben) begin
            put({11'b0, wbreg}, 1'b0);
            put(wbdata[15:0], 1'b0);
            put(wbdata[31:16], 1'b1);
        end
    endtask

    task automatic add_ovf(input logic [15:0] cnt);
        put(DST, 1'b0);
        put(ID, 1'b0);
        put(16'h8800, 1'b0);
        put(cnt, 1'b1);
    endtask

    task automatic wait_flits(input int n, input int budget, input string tag);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            step(1);
            k++;
        end
        check({tag, "_count"}, got_q.size(), n);
    endtask

    task automatic compare_stream(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                check($sformatf("%s_d%0d", tag, i), got_q[i], exp_q[i]);
                check($sformatf("%s_l%0d", tag, i), got_last[i], exp_last[i]);
            end
        end
        got_q.delete();
        got_last.delete();
        exp_q.delete();
        exp_last.delete();
    endtask

    initial begin
        logic [31:0] ts;
        logic [31:0] ts_arr [11];
        int k;
        rst = 1'b1; enable = 1'b1; debug_out_ready = 1'b1;
        trace_valid = 1'b0; trace_pc = '0; trace_insn = '0;
        trace_wben = 1'b0; trace_wbreg = '0; trace_wbdata = '0;
        id = ID; dest = DST;
        step(2);
        rst = 1'b0;

        // reset state, cycle 0
        check("rst_valid", debug_out_valid, 1'b0);
        check("rst_last", debug_out_last, 1'b0);
        check("rst_data", debug_out_data, 16'h0);
        check("rst_ovf", overflow_cnt, 16'h0);
        check("rst_busy", busy, 1'b0);

        // first EXEC record at cycle 10, first flit at cycle 12
        step(10);
        offer(32'h0000C000, 32'h40314400, 1'b0, 5'd0, 32'h0, ts);
        check("t1_c11_valid", debug_out_valid, 1'b0);
        step(1);
        check("t1_c12_valid", debug_out_valid, 1'b1);
        check("t1_c12_data", debug_out_data, DST);
        add_exec(32'h0000C000, 32'h40314400, 1'b0, 5'd0, 32'h0, 32'd10);
        wait_flits(9, 40, "t1");
        compare_stream("t1");

        // EXEC_WB record
        offer(32'h0000C002, 32'h4F0F4503, 1'b1, 5'd3, 32'h000000FF, ts);
        add_exec(32'h0000C002, 32'h4F0F4503, 1'b1, 5'd3, 32'h000000FF, ts);
        wait_flits(12, 40, "t2");
        compare_stream("t2");

        // stall on the fifth flit for 20 cycles
        offer(32'h0000C010, 32'h12345678, 1'b0, 5'd0, 32'h0, ts);
        add_exec(32'h0000C010, 32'h12345678, 1'b0, 5'd0, 32'h0, ts);
        step(1);
        step(4);
        debug_out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("t3_hold_valid", debug_out_valid, 1'b1);
            check("t3_hold_data", debug_out_data, exp_q[4]);
            check("t3_hold_last", debug_out_last, 1'b0);
            step(1);
        end
        debug_out_ready = 1'b1;
        wait_flits(9, 40, "t3");
        compare_stream("t3");

        // overflow: packet stuck on DEST, then 11 records into an 8-deep FIFO
        debug_out_ready = 1'b0;
        offer(32'h0000D000, 32'hAAAA5555, 1'b0, 5'd0, 32'h0, ts);
        add_exec(32'h0000D000, 32'hAAAA5555, 1'b0, 5'd0, 32'h0, ts);
        step(1);
        check("t4_stuck_valid", debug_out_valid, 1'b1);
        for (int i = 0; i < 11; i++)
            offer(32'h00000100 + 32'(i), 32'h40300000 + 32'(i), 1'b0, 5'd0, 32'h0, ts_arr[i]);
        check("t4_ovf_cnt", overflow_cnt, 16'd3);
        check("t4_busy", busy, 1'b1);
        add_ovf(16'd3);
        for (int i = 0; i < 8; i++)
            add_exec(32'h00000100 + 32'(i), 32'h40300000 + 32'(i), 1'b0, 5'd0, 32'h0, ts_arr[i]);
        debug_out_ready = 1'b1;
        k = 0;
        while (got_q.size() < 9 && k < 50) begin
            step(1);
            k++;
        end
        check("t4_ovf_dest", debug_out_data, DST);
        check("t4_ovf_clr", overflow_cnt, 16'd0);
        wait_flits(85, 400, "t4");
        compare_stream("t4");
        check("t4_idle_busy", busy, 1'b0);

        // reset during the fifth flit, then a clean packet with restarted timestamp
        offer(32'h0000E000, 32'h11112222, 1'b0, 5'd0, 32'h0, ts);
        step(1);
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t5_valid", debug_out_valid, 1'b0);
        check("t5_last", debug_out_last, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_ovf", overflow_cnt, 16'd0);
        got_q.delete();
        got_last.delete();
        step(3);
        offer(32'h0000E100, 32'h33334444, 1'b0, 5'd0, 32'h0, ts);
        add_exec(32'h0000E100, 32'h33334444, 1'b0, 5'd0, 32'h0, 32'd3);
        wait_flits(9, 40, "t5");
        compare_stream("t5");

        // tracing disabled: nothing captured or counted
        enable = 1'b0;
        for (int i = 0; i < 5; i++)
            offer(32'h0000F000 + 32'(i), 32'h0, 1'b0, 5'd0, 32'h0, ts);
        step(20);
        check("t6_flits", got_q.size(), 0);
        check("t6_ovf", overflow_cnt, 16'd0);
        check("t6_busy", busy, 1'b0);
        check("t6_valid", debug_out_valid, 1'b0);
        enable = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/msp430_trace_dii_tx.md
Name: msp430_trace_dii_tx

Overview:
- Transmit end of the per-core execution-trace path.
- Captures retired-instruction records from one MSP430 core: valid, pc, insn, wben, wbreg, wbdata.
- Buffers the records and serialises each one into a debug-interconnect (DII) event packet of 16-bit flits, for the on-chip debug router to carry to the host-side trace receiver.
- One instance per core inside each compute tile, next to the trace tap, when USE_DEBUG=1.

Parameters:
- FIFO_DEPTH, 8: trace record buffer entries; power of two, at least 2.
- MAX_PKT_LEN, 12: maximum flits per packet; the largest packet generated is exactly 12.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- id  in  16  own DII address (SRC field)
- dest  in  16  DII address of trace receiver
- enable  in  1  tracing enabled
- trace_valid  in  1  instruction retired this cycle
- trace_pc  in  32  retired PC
- trace_insn  in  32  retired instruction word
- trace_wben  in  1  register write-back valid
- trace_wbreg  in  5  write-back register index
- trace_wbdata  in  32  write-back data
- debug_out_data  out  16  DII flit data
- debug_out_valid  out  1  flit valid
- debug_out_last  out  1  last flit of packet
- debug_out_ready  in  1  downstream accepts flit
- overflow_cnt  out  16  records dropped since the last overflow packet
- busy  out  1  FIFO non-empty or packet in flight

Behaviour:
- Reset: synchronous to clk, active-high. All outputs are 0 in the cycle after rst is sampled high. FIFO is emptied, timestamp is 0, FSM is IDLE. A packet in progress is abandoned without asserting last.
- Timestamp: 32-bit free-running counter; increments every non-reset cycle and wraps 0xFFFFFFFF to 0.
- Capture:
  - trace_valid & enable with FIFO not full: record plus current timestamp written in cycle N.
  - trace_valid & enable with FIFO full: record dropped; overflow_cnt increments, saturating at 0xFFFF.
  - enable=0: records ignored and not counted; a packet already in flight completes.
  - FIFO full with a pop in the same cycle still counts as full: record dropped.
- Handshake:
  - A flit transfers when debug_out_valid & debug_out_ready.
  - While valid is high and ready is low, data, valid and last hold stable.
  - Outputs are registered.
  - With FIFO empty and FSM idle, the first flit of a record captured in cycle N is valid in cycle N+2.
  - Back-to-back packets: no idle cycle between the last flit of one packet and DEST of the next.
- Packet format, in flit order:
  - DEST, SRC=id, TYPE.
  - TYPE = {2'b10, subtype[3:0], 10'b0}; subtype EXEC=0, EXEC_WB=1, OVERFLOW=2.
  - EXEC: TS_LO, TS_HI, PC_LO, PC_HI, INSN_LO, INSN_HI; 9 flits.
  - EXEC_WB: EXEC payload, then {11'b0, wbreg}, WBDATA_LO, WBDATA_HI; 12 flits.
  - OVERFLOW: COUNT; 4 flits.
- FSM:
  - States: IDLE, HDR_DEST, HDR_SRC, HDR_TYPE, PAYLOAD, OVF_CNT.
  - IDLE leaves when overflow_cnt≠0 or FIFO is non-empty.
  - Overflow has priority. The OVERFLOW packet latches the count at HDR_DEST entry and zeroes overflow_cnt in that same cycle. Drops during the packet count from 0, or from 1 if a drop coincides with the clear.
  - Otherwise pop the FIFO head into the packet register at HDR_DEST entry.
  - PAYLOAD uses a 4-bit flit index; last is asserted on the final flit; the FSM returns to IDLE or starts the next packet.
- Header fields: dest and id are sampled at HDR_DEST entry and held for the whole packet.
- busy = FIFO non-empty | FSM≠IDLE | overflow_cnt≠0.

Decomposition:
- Shared package msp430_trace_dii_pkg:
  - trace_rec_t struct: pc, insn, wben, wbreg, wbdata, ts.
  - TYPE class constant and subtype constants.
  - Packet length constants 9/12/4.
- Sub-module trace_rec_fifo: synchronous single-clock FIFO of trace_rec_t with FIFO_DEPTH, full/empty flags, registered head output.

Test Plan:
- Reset, then trace_valid at cycle 10 with pc=0x0000C000, insn=0x40314400, wben=0, ready=1 -> flits from cycle 12: dest, id, 0x8000, ts lo/hi=10/0, 0xC000, 0x0000, 0x4400, 0x4031; last on the 9th flit.
- Record with wben=1, wbreg=3, wbdata=0x000000FF -> TYPE 0x8400, 12 flits, tail 0x0003, 0x00FF, 0x0000 with last.
- ready held 0 for 20 cycles mid-packet -> data, valid, last unchanged throughout; the packet completes once ready=1.
- ready=0, 11 consecutive records with FIFO_DEPTH=8 -> overflow_cnt=3. Release ready -> OVERFLOW packet (TYPE 0x8800, COUNT=3, 4 flits) precedes the 8 EXEC packets; overflow_cnt=0 after its DEST.
- rst pulsed during flit 5 of a packet -> next cycle valid=0, busy=0, overflow_cnt=0. After reset, a new record produces a clean packet with timestamp restarted from 0.
- enable=0 with 5 records offered -> no packets, overflow_cnt=0, busy=0.
